sr_decode_stage: RTL
====================

# sr_decode_stage

Registered, parametrised RISC-V RV32I/RV64I decode stage for the schoolRISCV pipeline. It accepts a fetched instruction word and PC over a valid/ready handshake and splits out the register fields. It selects one sign-extended immediate of XLEN bits covering all six base formats (R/I/S/B/U/J), plus an illegal-opcode flag. Results are presented one cycle later behind a two-entry skid buffer, so the fetch and execute stages see full throughput and no combinational ready path between them.

## Interface
Parameters:
- XLEN, 32: datapath width for `out_imm`, `in_pc` and `out_pc`; legal values are 32 and 64.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards every held entry.
- in_valid  in  1  upstream entry is present.
- in_ready  out  1  stage can accept an entry; driven from a register.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of the instruction.
- out_valid  out  1  decoded entry is present.
- out_ready  in  1  downstream accepts the entry.
- out_pc  out  XLEN  PC passed through unchanged.
- out_op  out  7  instr[6:0].
- out_rd  out  5  instr[11:7].
- out_f3  out  3  instr[14:12].
- out_rs1  out  5  instr[19:15].
- out_rs2  out  5  instr[24:20].
- out_f7  out  7  instr[31:25].
- out_imm  out  XLEN  selected immediate, sign-extended from instr[31].
- out_fmt  out  3  immediate format, of type imm_fmt_t.
- out_illegal  out  1  unknown opcode, or instr[1:0] != 2'b11.

## Operation
- Format selection by opcode:
  - I: 0010011, 0000011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011.
  - Any other opcode: format R, imm 0, illegal 1.
- Immediate bit layouts (before sign extension):
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}. For XLEN=64 this is also sign-extended from bit 31.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R = 0.
- Decode is combinational on the input side. The stored entry is the full decoded bundle, not the raw instruction word.
- Storage is two slots: a main slot (drives the outputs) and a skid slot. Each slot has a valid bit.
- An entry is accepted in a cycle when in_valid && in_ready && !flush.
- Where an accepted entry goes:
  - It goes into the main slot if main is empty, or if main is being consumed this cycle (out_valid && out_ready).
  - Otherwise it goes into the skid slot.
- Consume: when out_valid && out_ready and the skid slot is valid, skid moves to main in the same edge.
- in_ready next cycle = !skid_valid next cycle.
- Entries leave in acceptance order. No entry is lost or duplicated.
- flush clears both valid bits at the next edge and has priority over accept and consume. in_ready is 1 on the following cycle.

## Timing
- Latency: an entry accepted at edge N is shown on the outputs after edge N (out_valid=1) when the main slot was free.
- Throughput: one entry per cycle while out_ready=1.
- Data outputs stay stable while out_valid && !out_ready.
- Reset values (asynchronous):
  - out_valid=0, in_ready=1.
  - Every data output is 0, including out_fmt=FMT_R and out_illegal=0.
- Reset during a stall drops both entries immediately.
- Data outputs when out_valid=0 are don't-care after the first accept. Verification checks them only when out_valid=1.
- Simultaneous accept and consume with skid empty keeps exactly one entry in main, and in_ready stays 1.
- in_valid while in_ready=0 has no effect. Upstream must hold the entry.

## Structure
- Package sr_decode_pkg holds:
  - imm_fmt_t enum: FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5.
  - Opcode localparams: OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG.
  - Packed struct dec_bundle_t for slot storage, parametrised through XLEN at its use site.
- Sub-module sr_imm_gen (parameter XLEN): purely combinational. Takes the instruction and outputs imm, fmt and illegal. The stage instantiates it once on the input side.

## Test plan
- Reset: assert rst mid-cycle -> immediately out_valid=0, in_ready=1, out_imm=0, out_fmt=FMT_R.
- addi x1,x0,-1 (0xFFF00093), XLEN=64 -> next cycle out_valid=1, rd=1, fmt=FMT_I, out_imm=0xFFFF_FFFF_FFFF_FFFF.
- beq x0,x0,-4 (0xFE000EE3) -> fmt=FMT_B, imm=0xFFFFFFFC.
- sw x1,12(x2) (0x00112623) -> fmt=FMT_S, imm=12, rs1=2, rs2=1.
- out_ready=0, push instructions A, B, C back-to-back:
  - A sits in main, B in skid, in_ready=0 from the cycle after B's accept, and C is held.
  - Then out_ready=1 -> outputs A, B, C on consecutive cycles with no gaps.
- 0x00000000 -> out_illegal=1, fmt=FMT_R, imm=0.
- Flush with both slots full -> next cycle out_valid=0, in_ready=1.
- Flush asserted together with in_valid -> the entry offered that cycle is not accepted.

Source files
------------

// File: rtl/sr_decode_pkg.sv
// Shared types and opcode constants for the schoolRISCV decode stage.
package sr_decode_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // XLEN-independent part of a decoded entry; pc/imm are wrapped around it
  // by dec_bundle_t inside the stage, where XLEN is known.
  typedef struct packed {
    logic [6:0] op;
    logic [4:0] rd;
    logic [2:0] f3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] f7;
    imm_fmt_t   fmt;
    logic       illegal;
  } dec_fields_t;

endpackage

// File: rtl/sr_imm_gen.sv
// Combinational immediate generator: format select, bit layout and
// sign extension to XLEN, plus the illegal-opcode flag.
module sr_imm_gen
  import sr_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt,
  output logic            illegal
);

  logic [31:0] imm32;

  always_comb begin
    fmt     = FMT_R;
    illegal = 1'b0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt = FMT_I;
      OP_STORE:                            fmt = FMT_S;
      OP_BRANCH:                           fmt = FMT_B;
      OP_LUI, OP_AUIPC:                    fmt = FMT_U;
      OP_JAL:                              fmt = FMT_J;
      OP_REG:                              fmt = FMT_R;
      default:                             illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) illegal = 1'b1;
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_wide
      assign imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
      assign imm = imm32;
    end
  endgenerate

endmodule

// File: rtl/sr_decode_stage.sv
// Registered RV32I/RV64I decode stage with a two-slot skid buffer so that
// in_ready comes straight from a flop and full throughput is kept.
module sr_decode_stage
  import sr_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_op,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_f3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_f7,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_t        out_fmt,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    dec_fields_t     f;
  } dec_bundle_t;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_t        dec_fmt;
  logic            dec_illegal;
  dec_bundle_t     dec;

  sr_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  always_comb begin
    dec           = '0;
    dec.pc        = in_pc;
    dec.imm       = dec_illegal ? '0 : dec_imm;
    dec.f.op      = in_instr[6:0];
    dec.f.rd      = in_instr[11:7];
    dec.f.f3      = in_instr[14:12];
    dec.f.rs1     = in_instr[19:15];
    dec.f.rs2     = in_instr[24:20];
    dec.f.f7      = in_instr[31:25];
    dec.f.fmt     = dec_illegal ? FMT_R : dec_fmt;
    dec.f.illegal = dec_illegal;
  end

  dec_bundle_t main_q, skid_q, main_d, skid_d;
  logic        main_v, skid_v, main_v_d, skid_v_d;
  logic        in_ready_q;
  logic        accept, consume;

  assign accept  = in_valid && in_ready_q && !flush;
  assign consume = main_v && out_ready;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v;
    skid_v_d = skid_v;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      if (consume) begin
        if (skid_v) begin
          main_d   = skid_q;
          skid_v_d = 1'b0;
        end else begin
          main_v_d = 1'b0;
        end
      end
      // accept implies the skid slot is empty, so at most one slot fills here
      if (accept) begin
        if (!main_v || consume) begin
          main_d   = dec;
          main_v_d = 1'b1;
        end else begin
          skid_d   = dec;
          skid_v_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_v     <= 1'b0;
      skid_v     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_v     <= main_v_d;
      skid_v     <= skid_v_d;
      in_ready_q <= !skid_v_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_v;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_op      = main_q.f.op;
  assign out_rd      = main_q.f.rd;
  assign out_f3      = main_q.f.f3;
  assign out_rs1     = main_q.f.rs1;
  assign out_rs2     = main_q.f.rs2;
  assign out_f7      = main_q.f.f7;
  assign out_fmt     = main_q.f.fmt;
  assign out_illegal = main_q.f.illegal;

endmodule
